// File: rtl/config_pkg.sv
// Core-wide configuration shared by the memory-system blocks.
package config_pkg;
    localparam int PA_BITS = 34;
endpackage

// File: rtl/pmparb_pkg.sv
// Shared types and helpers for the PMP check arbiter (pmp_check_arbiter and pmparb_prio).
package pmparb_pkg;
    import config_pkg::*;

    localparam int PMPARB_MAX_REQ = 16;
    localparam int PMPARB_ID_W    = 4;

    typedef enum logic [1:0] {
        PMPARB_READ  = 2'b00,
        PMPARB_WRITE = 2'b01,
        PMPARB_EXEC  = 2'b10,
        PMPARB_AMO   = 2'b11
    } pmparb_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        HOLD  = 2'b10
    } pmparb_state_t;

    typedef struct packed {
        logic                   valid;
        logic [PMPARB_ID_W-1:0] id;
        logic [PA_BITS-1:0]     padr;
        logic [1:0]             size;
        logic [1:0]             priv;
        pmparb_type_t           typ;
    } pmparb_stage_t;

    // Checker strobes as {exec, read, write}; an AMO needs both read and write permission.
    function automatic logic [2:0] pmparb_strobes(input pmparb_type_t t);
        case (t)
            PMPARB_READ:  return 3'b010;
            PMPARB_WRITE: return 3'b001;
            PMPARB_EXEC:  return 3'b100;
            default:      return 3'b011;
        endcase
    endfunction

    function automatic logic [PMPARB_MAX_REQ-1:0] pmparb_lowest(input logic [PMPARB_MAX_REQ-1:0] v);
        return v & (~v + PMPARB_MAX_REQ'(1));
    endfunction
endpackage

// File: rtl/pmparb_prio.sv
// One-hot grant selection for the PMP check arbiter; fixed priority, plus starvation
// counters when PMPARB_STARVE_GUARD_EN is defined.
module pmparb_prio
    import pmparb_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int STARVE_LIMIT = 4
) (
`ifdef PMPARB_STARVE_GUARD_EN
    input  logic             clk,
    input  logic             reset,
`endif
    input  logic [N_REQ-1:0] req_valid,
    input  logic             grant_en,
    output logic [N_REQ-1:0] grant
);

    if (STARVE_LIMIT < 1 || N_REQ < 1 || N_REQ > PMPARB_MAX_REQ) begin : g_bad_cfg
        $error("pmparb_prio: unsupported N_REQ/STARVE_LIMIT");
    end

    logic [N_REQ-1:0] sel;

`ifdef PMPARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt [N_REQ];
    logic [N_REQ-1:0] starved;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_W'(STARVE_LIMIT)) ? CNT_W'(STARVE_LIMIT) : c + CNT_W'(1);
    endfunction

    always_comb begin
        starved = '0;
        for (int i = 0; i < N_REQ; i++) begin
            starved[i] = req_valid[i] && (wait_cnt[i] >= CNT_W'(STARVE_LIMIT));
        end
    end

    // Starved requesters preempt base priority; the lowest starved index wins.
    always_comb sel = (|starved) ? starved : req_valid;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (reset || !req_valid[i] || grant[i]) begin
                wait_cnt[i] <= '0;
            end else begin
                wait_cnt[i] <= sat_inc(wait_cnt[i]);
            end
        end
    end
`else
    always_comb sel = req_valid;
`endif

    always_comb grant = grant_en ? N_REQ'(pmparb_lowest(PMPARB_MAX_REQ'(sel))) : '0;

endmodule

// File: rtl/pmp_check_arbiter.sv
// Shares one PMP checker between HPTW/LSU/IFU with a 1-cycle check stage and CSR-write freeze.
// Optional starvation guard: define PMPARB_STARVE_GUARD_EN.
module pmp_check_arbiter
    import config_pkg::*;
    import pmparb_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         ReqValid,
    output logic [N_REQ-1:0]         ReqReady,
    input  logic [N_REQ*PA_BITS-1:0] ReqPAdr,
    input  logic [N_REQ*2-1:0]       ReqSize,
    input  logic [N_REQ*2-1:0]       ReqType,
    input  logic [N_REQ*2-1:0]       ReqPriv,
    output logic [N_REQ-1:0]         RspValid,
    output logic [N_REQ-1:0]         RspFault,
    input  logic                     PmpCsrWrM,
    input  logic                     FlushM,
    output logic [PA_BITS-1:0]       ChkPAdr,
    output logic [1:0]               ChkSize,
    output logic [1:0]               ChkPriv,
    output logic                     ChkExec,
    output logic                     ChkRead,
    output logic                     ChkWrite,
    input  logic                     ChkInstrFault,
    input  logic                     ChkLoadFault,
    input  logic                     ChkStoreFault
);

    pmparb_state_t    state_p1, state_nxt;
    pmparb_stage_t    stage_p1, stage_nxt;
    logic             grant_en;
    logic [N_REQ-1:0] grant;
    logic             fault_sel;
    logic             rsp_fire;

    // Grants freeze during a CSR commit and the following HOLD cycle.
    assign grant_en = !reset && !PmpCsrWrM && (state_p1 != HOLD);

    pmparb_prio #(
        .N_REQ        (N_REQ),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
`ifdef PMPARB_STARVE_GUARD_EN
        .clk       (clk),
        .reset     (reset),
`endif
        .req_valid (ReqValid),
        .grant_en  (grant_en),
        .grant     (grant)
    );

    assign ReqReady = grant;

    always_comb begin
        stage_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                stage_nxt.valid = 1'b1;
                stage_nxt.id    = PMPARB_ID_W'(i);
                stage_nxt.padr  = ReqPAdr[i*PA_BITS +: PA_BITS];
                stage_nxt.size  = ReqSize[2*i +: 2];
                stage_nxt.priv  = ReqPriv[2*i +: 2];
                stage_nxt.typ   = pmparb_type_t'(ReqType[2*i +: 2]);
            end
        end
        if (PmpCsrWrM) begin
            state_nxt = HOLD;
        end else if (stage_nxt.valid) begin
            state_nxt = CHECK;
        end else begin
            state_nxt = IDLE;
        end
    end

    // ---- stage boundary: grant -> check stage (the stage always drains, so flush just lets it empty)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= IDLE;
            stage_p1 <= '0;
        end else begin
            state_p1 <= state_nxt;
            stage_p1 <= stage_nxt;
        end
    end

    assign ChkPAdr = stage_p1.padr;
    assign ChkSize = stage_p1.size;
    assign ChkPriv = stage_p1.priv;
    assign {ChkExec, ChkRead, ChkWrite} = stage_p1.valid ? pmparb_strobes(stage_p1.typ) : 3'b000;

    always_comb begin
        case (stage_p1.typ)
            PMPARB_EXEC: fault_sel = ChkInstrFault;
            PMPARB_READ: fault_sel = ChkLoadFault;
            default:     fault_sel = ChkStoreFault;
        endcase
    end

    assign rsp_fire = stage_p1.valid && !FlushM && !reset;

    always_comb begin
        RspValid = '0;
        RspFault = '0;
        for (int i = 0; i < N_REQ; i++) begin
            RspValid[i] = rsp_fire && (stage_p1.id == PMPARB_ID_W'(i));
            RspFault[i] = RspValid[i] && fault_sel;
        end
    end

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Bench for pmp_check_arbiter: directed vector table, corner sequences, random run vs. model.
module tb_pmp_check_arbiter;
    import config_pkg::*;

    localparam int N     = 3;
    localparam int LIMIT = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         ReqValid, ReqReady, RspValid, RspFault;
    logic [N*PA_BITS-1:0] ReqPAdr;
    logic [2*N-1:0]       ReqSize, ReqType, ReqPriv;
    logic                 PmpCsrWrM, FlushM;
    logic [PA_BITS-1:0]   ChkPAdr;
    logic [1:0]           ChkSize, ChkPriv;
    logic                 ChkExec, ChkRead, ChkWrite;
    logic                 ChkInstrFault, ChkLoadFault, ChkStoreFault;

    pmp_check_arbiter #(.N_REQ(N), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqPAdr(ReqPAdr), .ReqSize(ReqSize), .ReqType(ReqType), .ReqPriv(ReqPriv),
        .RspValid(RspValid), .RspFault(RspFault), .PmpCsrWrM(PmpCsrWrM), .FlushM(FlushM),
        .ChkPAdr(ChkPAdr), .ChkSize(ChkSize), .ChkPriv(ChkPriv),
        .ChkExec(ChkExec), .ChkRead(ChkRead), .ChkWrite(ChkWrite),
        .ChkInstrFault(ChkInstrFault), .ChkLoadFault(ChkLoadFault), .ChkStoreFault(ChkStoreFault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(ReqReady), 64'd0);
        check({tag, "_rspv"}, 64'(RspValid), 64'd0);
        check({tag, "_rspf"}, 64'(RspFault), 64'd0);
        check({tag, "_strobes"}, 64'({ChkExec, ChkRead, ChkWrite}), 64'd0);
        check({tag, "_padr"}, 64'(ChkPAdr), 64'd0);
        check({tag, "_size_priv"}, 64'({ChkSize, ChkPriv}), 64'd0);
    endtask

    typedef struct {
        logic [2:0] vld;
        logic [5:0] typ;
        logic       csr, flush, fi, fl, fs;
        logic [2:0] exp_rdy, exp_rv, exp_rf;
    } vec_t;

    vec_t tbl[19];
    logic [PA_BITS-1:0] fixed_padr [N];

    // Behavioural reference: the stage is "what was granted last cycle"; HOLD is "a CSR write happened last cycle".
    logic               m_vld, m_hold;
    int                 m_id;
    logic [1:0]         m_typ, m_size, m_priv;
    logic [PA_BITS-1:0] m_padr;
    int                 m_wait [N];

    function automatic logic [2:0] model_pick(input logic [2:0] v);
`ifdef PMPARB_STARVE_GUARD_EN
        for (int i = 0; i < N; i++) begin
            if (v[i] && m_wait[i] >= LIMIT) return 3'(1 << i);
        end
`endif
        for (int i = 0; i < N; i++) begin
            if (v[i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_vld = 1'b0; m_hold = 1'b0; m_id = 0;
        m_typ = '0; m_size = '0; m_priv = '0; m_padr = '0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_rdy, exp_rv, exp_rf, g;
        logic       flt;

        fixed_padr[0] = 34'h0_8000_1000;
        fixed_padr[1] = 34'h0_8000_0000;
        fixed_padr[2] = 34'h0_8000_2000;

        //          vld     typ         csr flush fi fl fs  rdy     rv      rf
        tbl[0]  = '{3'b010, 6'b10_01_00, 0, 0, 0, 0, 0, 3'b010, 3'b000, 3'b000};
        tbl[1]  = '{3'b000, 6'b10_01_00, 0, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000};
        tbl[2]  = '{3'b111, 6'b10_01_00, 0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000};
        tbl[3]  = '{3'b110, 6'b10_01_00, 0, 0, 0, 1, 0, 3'b010, 3'b001, 3'b001};
        tbl[4]  = '{3'b100, 6'b10_01_00, 0, 0, 0, 1, 0, 3'b100, 3'b010, 3'b000};
        tbl[5]  = '{3'b000, 6'b10_01_00, 0, 0, 1, 0, 0, 3'b000, 3'b100, 3'b100};
        tbl[6]  = '{3'b001, 6'b10_01_11, 0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000};
        tbl[7]  = '{3'b100, 6'b10_01_11, 0, 0, 0, 0, 1, 3'b100, 3'b001, 3'b001};
        tbl[8]  = '{3'b000, 6'b10_01_11, 0, 0, 0, 1, 1, 3'b000, 3'b100, 3'b000};
        tbl[9]  = '{3'b010, 6'b10_01_00, 0, 0, 0, 0, 0, 3'b010, 3'b000, 3'b000};
        tbl[10] = '{3'b111, 6'b10_01_00, 1, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000};
        tbl[11] = '{3'b111, 6'b10_01_00, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000};
        tbl[12] = '{3'b111, 6'b10_01_00, 0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000};
        tbl[13] = '{3'b010, 6'b10_01_00, 0, 0, 0, 1, 0, 3'b010, 3'b001, 3'b001};
        tbl[14] = '{3'b000, 6'b10_01_00, 0, 1, 1, 1, 1, 3'b000, 3'b000, 3'b000};
        tbl[15] = '{3'b000, 6'b10_01_00, 0, 0, 1, 1, 1, 3'b000, 3'b000, 3'b000};
        tbl[16] = '{3'b001, 6'b10_01_00, 0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000};
        tbl[17] = '{3'b100, 6'b10_01_00, 0, 1, 1, 1, 1, 3'b100, 3'b000, 3'b000};
        tbl[18] = '{3'b000, 6'b10_01_00, 0, 0, 0, 1, 1, 3'b000, 3'b100, 3'b000};

        reset = 1'b1; ReqValid = '0; ReqType = '0; ReqSize = '0; ReqPriv = '0; ReqPAdr = '0;
        PmpCsrWrM = 1'b0; FlushM = 1'b0;
        ChkInstrFault = 1'b0; ChkLoadFault = 1'b0; ChkStoreFault = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");

        for (int i = 0; i < N; i++) begin
            ReqPAdr[i*PA_BITS +: PA_BITS] = fixed_padr[i];
            ReqSize[2*i +: 2] = 2'b10;
            ReqPriv[2*i +: 2] = 2'b01;
        end

        for (int k = 0; k < 19; k++) begin
            @(posedge clk); #1;
            ReqValid = tbl[k].vld; ReqType = tbl[k].typ;
            PmpCsrWrM = tbl[k].csr; FlushM = tbl[k].flush;
            ChkInstrFault = tbl[k].fi; ChkLoadFault = tbl[k].fl; ChkStoreFault = tbl[k].fs;
            @(negedge clk);
            check($sformatf("vec%0d_ready", k), 64'(ReqReady), 64'(tbl[k].exp_rdy));
            check($sformatf("vec%0d_rspv", k), 64'(RspValid), 64'(tbl[k].exp_rv));
            check($sformatf("vec%0d_rspf", k), 64'(RspFault), 64'(tbl[k].exp_rf));
            for (int i = 0; i < N; i++) begin
                if (tbl[k].exp_rv[i]) check($sformatf("vec%0d_padr", k), 64'(ChkPAdr), 64'(fixed_padr[i]));
            end
        end

        // Reset while the stage holds a check.
        @(posedge clk); #1;
        PmpCsrWrM = 1'b0; FlushM = 1'b0; ReqValid = 3'b010; ReqType = 6'b00_00_00;
        @(negedge clk);
        check("midrst_grant", 64'(ReqReady), 64'b010);
        @(posedge clk); #1;
        ReqValid = 3'b000; reset = 1'b1;
        @(negedge clk);
        check("midrst_no_rsp", 64'(RspValid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst_after");

`ifdef PMPARB_STARVE_GUARD_EN
        @(posedge clk); #1;
        ReqValid = 3'b101; ReqType = 6'b10_00_00;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("starve_c%0d", k), 64'(ReqReady), (k == 5) ? 64'b100 : 64'b001);
            if (k == 6) check("starve_rsp", 64'(RspValid), 64'b100);
            @(posedge clk); #1;
            if (k == 5) ReqValid = 3'b001;
        end
`endif

        @(posedge clk); #1;
        reset = 1'b1; ReqValid = '0; PmpCsrWrM = 1'b0; FlushM = 1'b0;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(63) == 0);
            ReqValid = 3'($urandom);
            ReqType = 6'($urandom); ReqSize = 6'($urandom); ReqPriv = 6'($urandom);
            for (int i = 0; i < N; i++) ReqPAdr[i*PA_BITS +: PA_BITS] = PA_BITS'({$urandom, $urandom});
            PmpCsrWrM = ($urandom_range(7) == 0);
            FlushM = ($urandom_range(7) == 0);
            {ChkInstrFault, ChkLoadFault, ChkStoreFault} = 3'($urandom);

            exp_rdy = (reset || PmpCsrWrM || m_hold) ? 3'b000 : model_pick(ReqValid);
            exp_rv = (m_vld && !FlushM && !reset) ? 3'(1 << m_id) : 3'b000;
            if (m_typ == 2'b10) flt = ChkInstrFault;
            else if (m_typ == 2'b00) flt = ChkLoadFault;
            else flt = ChkStoreFault;
            exp_rf = flt ? exp_rv : 3'b000;

            @(negedge clk);
            check("rnd_ready", 64'(ReqReady), 64'(exp_rdy));
            check("rnd_rspv", 64'(RspValid), 64'(exp_rv));
            check("rnd_rspf", 64'(RspFault), 64'(exp_rf));
            check("rnd_strobes", 64'({ChkExec, ChkRead, ChkWrite}),
                  64'({m_vld && m_typ == 2'b10,
                       m_vld && (m_typ == 2'b00 || m_typ == 2'b11),
                       m_vld && (m_typ == 2'b01 || m_typ == 2'b11)}));
            if (m_vld) check("rnd_chk_fields", 64'({ChkPAdr, ChkSize, ChkPriv}), 64'({m_padr, m_size, m_priv}));

            @(posedge clk);
            if (reset) begin
                model_reset();
            end else begin
                g = exp_rdy;
                m_hold = PmpCsrWrM;
                m_vld = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (g[i]) begin
                        m_vld = 1'b1; m_id = i;
                        m_typ = ReqType[2*i +: 2]; m_size = ReqSize[2*i +: 2];
                        m_priv = ReqPriv[2*i +: 2]; m_padr = ReqPAdr[i*PA_BITS +: PA_BITS];
                    end
                    if (g[i] || !ReqValid[i]) m_wait[i] = 0;
                    else if (m_wait[i] < LIMIT) m_wait[i] = m_wait[i] + 1;
                end
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
